tlv5618_rx: RTL and testbench

TLV5618_RX -- requirements
Module: tlv5618_rx

---
 rtl/tlv5618_rx_pkg.sv | 28 ++
 rtl/tlv5618_rx_sync_edge.sv | 37 +++
 rtl/tlv5618_rx.sv | 167 ++++++++++++++++
 tb/tb_tlv5618_rx.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/tlv5618_rx_pkg.sv
// Shared definitions for the TLV5618 serial-frame receiver.
//   state_t      : receiver FSM states
//   R_*          : frame control codes {D15, D12}
//   FRAME_BITS   : serial frame length
//   ctrl_code()  : extracts the control code from a received frame
package tlv5618_rx_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned DAC_W      = 12;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] R_WR_A   = 2'b10;
  localparam logic [1:0] R_WR_B   = 2'b00;
  localparam logic [1:0] R_WR_BUF = 2'b01;
  localparam logic [1:0] R_RSVD   = 2'b11;

  // Control code lives in bits D15 (R1) and D12 (R0).
  function automatic logic [1:0] ctrl_code(input logic [FRAME_BITS-1:0] frame);
    return {frame[15], frame[12]};
  endfunction

endpackage

// File: rtl/tlv5618_rx_sync_edge.sv
// Multi-stage synchroniser with an extra history register for edge detection.
//   clk, rst : system clock, synchronous active-high reset
//   din      : asynchronous input
//   level    : synchronised level (registered)
//   rise_c   : combinational one-cycle pulse on a synchronised rise
//   fall_c   : combinational one-cycle pulse on a synchronised fall
module sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] chain;
  logic              hist;

  // Reset value preloads the whole chain so no false edge follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
      hist  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      hist  <= chain[STAGES-1];
    end
  end

  assign level  = chain[STAGES-1];
  assign rise_c = chain[STAGES-1] & ~hist;
  assign fall_c = ~chain[STAGES-1] & hist;

endmodule

// File: rtl/tlv5618_rx.sv
// TLV5618-style serial DAC frame receiver.
//   sys_clk, sys_rst : system clock, synchronous active-high reset
//   cs               : frame select (active low, asynchronous)
//   dac_clk          : serial clock, data sampled on falling edge
//   series_dac_in    : serial data, MSB first
//   dac_a, dac_b     : latched DAC codes
//   dbl_buf          : double-buffer contents
//   spd, pwr         : D14 / D13 of the last accepted frame
//   frame_word       : raw last accepted frame
//   frame_valid      : one-cycle pulse on an accepted frame
//   frame_err        : one-cycle pulse on abort or reserved code
module tlv5618_rx
  import tlv5618_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cs,
  input  logic        dac_clk,
  input  logic        series_dac_in,
  output logic [11:0] dac_a,
  output logic [11:0] dac_b,
  output logic [11:0] dbl_buf,
  output logic        spd,
  output logic        pwr,
  output logic [15:0] frame_word,
  output logic        frame_valid,
  output logic        frame_err
);

  logic cs_level, cs_rise, cs_fall;
  logic clk_level, clk_rise, clk_fall;
  logic din, din_rise, din_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(sys_clk), .rst(sys_rst), .din(cs),
    .level(cs_level), .rise_c(cs_rise), .fall_c(cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
    .clk(sys_clk), .rst(sys_rst), .din(dac_clk),
    .level(clk_level), .rise_c(clk_rise), .fall_c(clk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dat (
    .clk(sys_clk), .rst(sys_rst), .din(series_dac_in),
    .level(din), .rise_c(din_rise), .fall_c(din_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{cs_level, clk_level, clk_rise, din_rise, din_fall};

  state_t                  state, state_d;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic [FRAME_BITS-1:0]   shreg, shreg_d;
  // Set for the one cycle after the 16th shift; the 4-bit counter has wrapped.
  logic                    pend, pend_d;
  logic [DAC_W-1:0]        dac_a_d, dac_b_d, dbl_buf_d;
  logic                    spd_d, pwr_d, valid_d, err_d;
  logic [FRAME_BITS-1:0]   word_d;

  // State and output registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      shreg       <= '0;
      pend        <= 1'b0;
      dac_a       <= '0;
      dac_b       <= '0;
      dbl_buf     <= '0;
      spd         <= 1'b0;
      pwr         <= 1'b0;
      frame_word  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      shreg       <= shreg_d;
      pend        <= pend_d;
      dac_a       <= dac_a_d;
      dac_b       <= dac_b_d;
      dbl_buf     <= dbl_buf_d;
      spd         <= spd_d;
      pwr         <= pwr_d;
      frame_word  <= word_d;
      frame_valid <= valid_d;
      frame_err   <= err_d;
    end
  end

  // Next-state, shift and decode logic.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    shreg_d   = shreg;
    pend_d    = 1'b0;
    dac_a_d   = dac_a;
    dac_b_d   = dac_b;
    dbl_buf_d = dbl_buf;
    spd_d     = spd;
    pwr_d     = pwr;
    word_d    = frame_word;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end

      ST_SHIFT: begin
        if (pend) begin
          // Full frame in shreg: decode it this cycle.
          unique case (ctrl_code(shreg))
            R_WR_A: begin
              dac_a_d = shreg[DAC_W-1:0];
              dac_b_d = dbl_buf;
              valid_d = 1'b1;
            end
            R_WR_B: begin
              dac_b_d   = shreg[DAC_W-1:0];
              dbl_buf_d = shreg[DAC_W-1:0];
              valid_d   = 1'b1;
            end
            R_WR_BUF: begin
              dbl_buf_d = shreg[DAC_W-1:0];
              valid_d   = 1'b1;
            end
            R_RSVD: begin
              err_d = 1'b1;
            end
          endcase
          if (valid_d) begin
            spd_d  = shreg[14];
            pwr_d  = shreg[13];
            word_d = shreg;
          end
          state_d = cs_rise ? ST_IDLE : ST_HOLD;
        end else if (cs_rise) begin
          // cs rise wins over a coincident dac_clk fall.
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (clk_fall) begin
          shreg_d = {shreg[FRAME_BITS-2:0], din};
          cnt_d   = cnt + CNT_W'(1);
          pend_d  = (cnt == CNT_W'(FRAME_BITS - 1));
        end
      end

      ST_HOLD: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tlv5618_rx.sv
// Self-checking bench for tlv5618_rx: directed frames plus randomized frames
// checked against a register-level model of the DAC command set.
module tb_tlv5618_rx;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        cs;
  logic        dac_clk;
  logic        series_dac_in;
  logic [11:0] dac_a, dac_b, dbl_buf;
  logic        spd, pwr;
  logic [15:0] frame_word;
  logic        frame_valid, frame_err;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_err = 0;

  // Model state.
  logic [11:0] m_a, m_b, m_buf;
  logic        m_spd, m_pwr;
  logic [15:0] m_word;
  int          e_valid, e_err;

  tlv5618_rx #(.SYNC_STAGES(2)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cs(cs), .dac_clk(dac_clk),
    .series_dac_in(series_dac_in), .dac_a(dac_a), .dac_b(dac_b),
    .dbl_buf(dbl_buf), .spd(spd), .pwr(pwr), .frame_word(frame_word),
    .frame_valid(frame_valid), .frame_err(frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  // Pulse counting and mutual-exclusion check, sampled mid-cycle.
  always @(negedge sys_clk) begin
    if (frame_valid) n_valid++;
    if (frame_err) n_err++;
    checks++;
    assert (!(frame_valid === 1'b1 && frame_err === 1'b1)) else begin
      errors++;
      $error("FAIL valid_err_overlap observed=1 expected=0");
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic model_reset();
    m_a = '0; m_b = '0; m_buf = '0; m_spd = 1'b0; m_pwr = 1'b0; m_word = '0;
  endtask

  // Command semantics of one frame of nbits bits followed by a cs rise.
  task automatic model_frame(input logic [15:0] w, input int nbits);
    logic [1:0] code;
    if (nbits < 16) begin
      e_err++;
    end else begin
      code = {w[15], w[12]};
      if (code == 2'b11) begin
        e_err++;
      end else begin
        e_valid++;
        m_spd  = w[14];
        m_pwr  = w[13];
        m_word = w;
        if (code == 2'b10) begin
          m_a = w[11:0];
          m_b = m_buf;
        end else if (code == 2'b00) begin
          m_b   = w[11:0];
          m_buf = w[11:0];
        end else begin
          m_buf = w[11:0];
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_dac_a"}, 32'(dac_a), 32'(m_a));
    check({tag, "_dac_b"}, 32'(dac_b), 32'(m_b));
    check({tag, "_dbl_buf"}, 32'(dbl_buf), 32'(m_buf));
    check({tag, "_spd"}, 32'(spd), 32'(m_spd));
    check({tag, "_pwr"}, 32'(pwr), 32'(m_pwr));
    check({tag, "_word"}, 32'(frame_word), 32'(m_word));
    check({tag, "_nvalid"}, 32'(n_valid), 32'(e_valid));
    check({tag, "_nerr"}, 32'(n_err), 32'(e_err));
  endtask

  // Shift nbits of w MSB first, then 'extra' random falls; 5-cycle phases.
  task automatic send_bits(input logic [15:0] w, input int nbits, input int extra);
    for (int i = 0; i < nbits + extra; i++) begin
      dac_clk = 1'b1;
      series_dac_in = (i < 16) ? w[15 - i] : 1'($urandom);
      wait_cyc(5);
      dac_clk = 1'b0;
      wait_cyc(5);
    end
  endtask

  task automatic run_frame(input logic [15:0] w, input int nbits, input int extra);
    cs = 1'b0;
    wait_cyc(6);
    send_bits(w, nbits, extra);
    wait_cyc(4);
    cs = 1'b1;
    wait_cyc(12);
    model_frame(w, nbits);
  endtask

  initial begin
    logic [15:0] w;
    int nb;
    sys_rst = 1'b1; cs = 1'b1; dac_clk = 1'b0; series_dac_in = 1'b0;
    e_valid = 0; e_err = 0;
    model_reset();
    wait_cyc(4);
    sys_rst = 1'b0;
    wait_cyc(4);
    check_all("reset");

    // Write A directly.
    run_frame(16'h8064, 16, 0);
    check_all("f8064");
    check("f8064_dac_a_const", 32'(dac_a), 32'h064);

    // Buffer write then write A transfers buffer to B.
    run_frame(16'h1ABC, 16, 0);
    check_all("f1abc");
    check("f1abc_buf_const", 32'(dbl_buf), 32'hABC);
    run_frame(16'h8123, 16, 0);
    check_all("f8123");
    check("f8123_dac_b_const", 32'(dac_b), 32'hABC);

    // Write B also loads the buffer.
    run_frame(16'h0555, 16, 0);
    check_all("f0555");

    // Abort after 9 bits, then a full frame.
    run_frame(16'h8AAA, 9, 0);
    check_all("abort9");
    run_frame(16'h8FFF, 16, 0);
    check_all("f8fff");
    check("f8fff_dac_a_const", 32'(dac_a), 32'hFFF);

    // Reserved code with 4 extra falls held in HOLD.
    run_frame(16'hD000, 16, 4);
    check_all("fd000_x20");

    // Extra falls after a valid frame are ignored too.
    run_frame(16'h6789, 16, 3);
    check_all("f6789_x19");

    // Reset at bit 8: cs released while reset is held, so no edge follows.
    cs = 1'b0;
    wait_cyc(6);
    send_bits(16'h8F0F, 8, 0);
    sys_rst = 1'b1;
    wait_cyc(2);
    cs = 1'b1;
    wait_cyc(3);
    sys_rst = 1'b0;
    n_valid = 0; n_err = 0; e_valid = 0; e_err = 0;
    model_reset();
    wait_cyc(20);
    check_all("midrst");
    run_frame(16'h8321, 16, 0);
    check_all("postrst");

    // Randomized frames, occasional aborts and trailing falls.
    for (int k = 0; k < 24; k++) begin
      w = 16'($urandom);
      nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 15)) : 16;
      run_frame(w, nb, (nb == 16) ? int'($urandom_range(0, 3)) : 0);
      check_all($sformatf("rnd%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
